// File: rtl/riscv_pkg.sv
// Shared defaults and state encoding for the integer register file.
package riscv_pkg;
   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: set on accepted allocation, cleared on writeback.
// REGFILE_BYPASS_EN: a same-cycle writeback hides the busy bit on matching read ports.
module regfile_sb_scoreboard
   import riscv_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRP   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_i,
   input  logic              alloc_valid_i,
   input  logic [AW-1:0]     alloc_rd_i,
   input  logic              wb_valid_i,
   input  logic [AW-1:0]     wb_rd_i,
   input  logic [NRP*AW-1:0] ra_i,
   output logic              alloc_ready_o,
   output logic [NRP-1:0]    rbusy_o
);
   logic [NREGS-1:0] busy_q, busy_d;
   logic             wb_wr;

   assign wb_wr = run_i & wb_valid_i & (wb_rd_i != '0);

   // A writeback landing this edge frees the slot, so a new writer may claim it.
   assign alloc_ready_o = run_i & ((alloc_rd_i == '0) | ~busy_q[alloc_rd_i] |
                                   (wb_valid_i & (wb_rd_i == alloc_rd_i)));

   always_comb begin
      busy_d = busy_q;
      if (wb_wr)
         busy_d[wb_rd_i] = 1'b0;
      if (alloc_valid_i && alloc_ready_o && (alloc_rd_i != '0))
         busy_d[alloc_rd_i] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   always_comb begin
      rbusy_o = '0;
      for (int i = 0; i < NRP; i++) begin
         if (run_i && (ra_i[i*AW +: AW] != '0)) begin
            rbusy_o[i] = busy_q[ra_i[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wb_valid_i && (wb_rd_i == ra_i[i*AW +: AW]))
               rbusy_o[i] = 1'b0;
`endif
         end
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// N-read/1-write integer register file with busy scoreboard and post-reset zeroing sequencer.
// REGFILE_BYPASS_EN: forward writeback data to matching read ports in the same cycle.
module regfile_sb
   import riscv_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRP   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                init_done,
   input  logic [NRP*AW-1:0]   ra,
   output logic [NRP*XLEN-1:0] rdata,
   output logic [NRP-1:0]      rbusy,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_rd,
   output logic                alloc_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_rd,
   input  logic [XLEN-1:0]     wb_data
);
   rf_state_e       state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [XLEN-1:0] mem_q [NREGS];
   logic            we;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we      = 1'b0;
      waddr   = wb_rd;
      wdata   = wb_data;
      case (state_q)
         INIT: begin
            we    = 1'b1;
            waddr = ptr_q;
            wdata = '0;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == AW'(NREGS - 1))
               state_d = RUN;
         end
         RUN: begin
            we = wb_valid & (wb_rd != '0);
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Contents are deliberately unreset; the sequencer clears them after every reset.
   always_ff @(posedge clk) begin
      if (we)
         mem_q[waddr] <= wdata;
   end

   assign init_done = (state_q == RUN);

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NRP; i++) begin
         if (init_done && (ra[i*AW +: AW] != '0)) begin
            rdata[i*XLEN +: XLEN] = mem_q[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wb_valid && (wb_rd == ra[i*AW +: AW]))
               rdata[i*XLEN +: XLEN] = wb_data;
`endif
         end
      end
   end

   regfile_sb_scoreboard #(
      .NREGS(NREGS),
      .NRP  (NRP),
      .AW   (AW)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .run_i        (init_done),
      .alloc_valid_i(alloc_valid),
      .alloc_rd_i   (alloc_rd),
      .wb_valid_i   (wb_valid),
      .wb_rd_i      (wb_rd),
      .ra_i         (ra),
      .alloc_ready_o(alloc_ready),
      .rbusy_o      (rbusy)
   );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus an NRP=4, XLEN=32 instance.
module tb_regfile_sb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Default instance: XLEN=64, NREGS=32, NRP=2
   logic         rst, init_done, alloc_valid, alloc_ready, wb_valid;
   logic [9:0]   ra;
   logic [127:0] rdata;
   logic [1:0]   rbusy;
   logic [4:0]   alloc_rd, wb_rd;
   logic [63:0]  wb_data;

   // Second instance: XLEN=32, NREGS=32, NRP=4
   logic         rst4, init_done4, alloc_valid4, alloc_ready4, wb_valid4;
   logic [19:0]  ra4;
   logic [127:0] rdata4;
   logic [3:0]   rbusy4;
   logic [4:0]   alloc_rd4, wb_rd4;
   logic [31:0]  wb_data4;

   regfile_sb dut (
      .clk(clk), .rst(rst), .init_done(init_done), .ra(ra), .rdata(rdata), .rbusy(rbusy),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   regfile_sb #(.XLEN(32), .NREGS(32), .NRP(4)) dut4 (
      .clk(clk), .rst(rst4), .init_done(init_done4), .ra(ra4), .rdata(rdata4), .rbusy(rbusy4),
      .alloc_valid(alloc_valid4), .alloc_rd(alloc_rd4), .alloc_ready(alloc_ready4),
      .wb_valid(wb_valid4), .wb_rd(wb_rd4), .wb_data(wb_data4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (init_done !== 1'b0 || rbusy !== 2'b00) begin
         errors++; $display("FAIL reset_state: init_done=%b rbusy=%b required 0/00", init_done, rbusy);
      end
      rst = 1'b0; rst4 = 1'b0;
      // writeback and allocation must both be ignored while clearing
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'hFFFF_FFFF_FFFF_FFFF;
      alloc_valid = 1'b1; alloc_rd = 5'd5;
      ra = {5'd5, 5'd3};
      for (int c = 1; c <= 32; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (init_done !== (c == 32) || init_done4 !== (c == 32)) begin
            errors++; $display("FAIL init_done_cycle%0d: got %b/%b required %b", c, init_done, init_done4, c == 32);
         end
         if (c < 32) begin
            checks++;
            if (alloc_ready !== 1'b0 || rdata !== 128'd0 || rbusy !== 2'b00) begin
               errors++; $display("FAIL init_outputs_cycle%0d: ready=%b rdata=%h rbusy=%b required 0/0/00", c, alloc_ready, rdata, rbusy);
            end
         end
      end
      wb_valid = 1'b0; alloc_valid = 1'b0;
      for (int r = 0; r < 32; r++) begin
         ra = {5'(r), 5'(r)};
         #1;
         checks++;
         if (rdata !== 128'd0 || rbusy !== 2'b00) begin
            errors++; $display("FAIL init_zero_x%0d: rdata=%h rbusy=%b required 0/00", r, rdata, rbusy);
         end
      end
   endtask

   task automatic test_basic();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF_0000_0001;
      tick();
      wb_valid = 1'b0;
      ra = {5'd0, 5'd5};
      #1;
      checks++;
      if (rdata[63:0] !== 64'hDEAD_BEEF_0000_0001 || rbusy[0] !== 1'b0) begin
         errors++; $display("FAIL basic_x5: rdata=%h rbusy=%b required deadbeef00000001/0", rdata[63:0], rbusy[0]);
      end
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h1;
      tick();
      wb_valid = 1'b0;
      ra = {5'd0, 5'd5};
      #1;
      checks++;
      if (rdata[127:64] !== 64'd0) begin
         errors++; $display("FAIL basic_x0: rdata=%h required 0", rdata[127:64]);
      end
   endtask

   task automatic test_scoreboard();
      alloc_valid = 1'b1; alloc_rd = 5'd7;
      #1;
      checks++;
      if (alloc_ready !== 1'b1) begin
         errors++; $display("FAIL sb_alloc1_ready: got %b required 1", alloc_ready);
      end
      tick();
      ra = {5'd7, 5'd7};
      #1;
      checks++;
      if (rbusy !== 2'b11) begin
         errors++; $display("FAIL sb_busy_set: rbusy=%b required 11", rbusy);
      end
      checks++;
      if (alloc_ready !== 1'b0) begin
         errors++; $display("FAIL sb_alloc2_refused: got %b required 0", alloc_ready);
      end
      tick();
      alloc_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'd42;
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (rdata[63:0] !== 64'd42 || rbusy !== 2'b00) begin
         errors++; $display("FAIL sb_wb_clear: rdata=%0d rbusy=%b required 42/00", rdata[63:0], rbusy);
      end
      alloc_valid = 1'b1; alloc_rd = 5'd7;
      #1;
      checks++;
      if (alloc_ready !== 1'b1) begin
         errors++; $display("FAIL sb_realloc_ready: got %b required 1", alloc_ready);
      end
      tick();
      alloc_rd = 5'd0;
      ra = {5'd0, 5'd7};
      #1;
      checks++;
      if (rbusy !== 2'b01 || alloc_ready !== 1'b1) begin
         errors++; $display("FAIL sb_realloc_busy_x0: rbusy=%b ready=%b required 01/1", rbusy, alloc_ready);
      end
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic test_same_cycle();
      alloc_valid = 1'b1; alloc_rd = 5'd9;
      tick();
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'd3;
      ra = {5'd9, 5'd0};
      #1;
      checks++;
      if (alloc_ready !== 1'b1) begin
         errors++; $display("FAIL same_cycle_ready: got %b required 1", alloc_ready);
      end
      tick();
      wb_valid = 1'b0; alloc_valid = 1'b0;
      #1;
      checks++;
      if (rdata[127:64] !== 64'd3 || rbusy[1] !== 1'b1) begin
         errors++; $display("FAIL same_cycle_x9: rdata=%0d rbusy=%b required 3/1", rdata[127:64], rbusy[1]);
      end
   endtask

   task automatic test_bypass();
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h11;
      tick();
      wb_valid = 1'b0;
      alloc_valid = 1'b1; alloc_rd = 5'd4;
      tick();
      alloc_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'hAA;
      ra = {5'd4, 5'd4};
      #1;
      checks++;
`ifdef REGFILE_BYPASS_EN
      if (rdata !== {64'hAA, 64'hAA} || rbusy !== 2'b00) begin
         errors++; $display("FAIL bypass_fwd: rdata=%h rbusy=%b required aa,aa/00", rdata, rbusy);
      end
`else
      if (rdata !== {64'h11, 64'h11} || rbusy !== 2'b11) begin
         errors++; $display("FAIL bypass_off: rdata=%h rbusy=%b required 11,11/11", rdata, rbusy);
      end
`endif
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (rdata !== {64'hAA, 64'hAA} || rbusy !== 2'b00) begin
         errors++; $display("FAIL bypass_after: rdata=%h rbusy=%b required aa,aa/00", rdata, rbusy);
      end
   endtask

   task automatic test_midop_reset();
      wb_valid4 = 1'b1; wb_rd4 = 5'd3; wb_data4 = 32'h55;
      tick();
      wb_valid4 = 1'b0;
      alloc_valid4 = 1'b1; alloc_rd4 = 5'd6;
      tick();
      alloc_valid4 = 1'b0;
      ra4 = {5'd3, 5'd3, 5'd6, 5'd3};
      #1;
      checks++;
      if (rdata4[31:0] !== 32'h55 || rbusy4 !== 4'b0010) begin
         errors++; $display("FAIL midop_pre: rdata=%h rbusy=%b required 55/0010", rdata4[31:0], rbusy4);
      end
      #2 rst4 = 1'b1;
      #1;
      checks++;
      if (init_done4 !== 1'b0 || rbusy4 !== 4'b0000 || rdata4 !== 128'd0) begin
         errors++; $display("FAIL midop_async: init_done=%b rbusy=%b rdata=%h required 0/0000/0", init_done4, rbusy4, rdata4);
      end
      tick();
      rst4 = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (init_done4 !== (c == 32)) begin
            errors++; $display("FAIL midop_init_cycle%0d: got %b required %b", c, init_done4, c == 32);
         end
      end
      ra4 = {5'd3, 5'd3, 5'd3, 5'd3};
      #1;
      checks++;
      if (rdata4 !== 128'd0) begin
         errors++; $display("FAIL midop_x3_zero: rdata=%h required 0", rdata4);
      end
      ra4 = {5'd6, 5'd6, 5'd6, 5'd6};
      alloc_valid4 = 1'b1; alloc_rd4 = 5'd6;
      #1;
      checks++;
      if (rbusy4 !== 4'b0000 || alloc_ready4 !== 1'b1) begin
         errors++; $display("FAIL midop_busy_cleared: rbusy=%b ready=%b required 0000/1", rbusy4, alloc_ready4);
      end
      alloc_valid4 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst4 = 1'b1;
      ra = '0; alloc_valid = 1'b0; alloc_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      ra4 = '0; alloc_valid4 = 1'b0; alloc_rd4 = '0; wb_valid4 = 1'b0; wb_rd4 = '0; wb_data4 = '0;
      test_reset();
      test_basic();
      test_scoreboard();
      test_same_cycle();
      test_bypass();
      test_midop_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
